wb_regfile: RTL and testbench

- Write-back stage plus architectural register file for the 5-stage MIPS core.
- Directly downstream of the memory-access stage: registers that stage's register-write result, commits it to a 32x32 register file one cycle later, serves the two decode-stage read ports with write-first bypass, and exports forwarding, debug-trace and retire-count signals.

---
 rtl/wb_regfile.sv | 121 ++++++++++++
 tb/tb_wb_regfile.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage register and 32x32 architectural register file for the MIPS core:
// write-first read bypass, forwarding taps, commit trace and retired-instruction counter.
module wb_regfile #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      regData_i,
    input  logic [4:0]       regAddr_i,
    input  logic             regWr_i,
    input  logic             valid_i,
    input  logic [31:0]      inst_debug_i,
    input  logic [31:0]      pc_debug_i,
    input  logic [4:0]       raddr1,
    input  logic [4:0]       raddr2,
    output logic [31:0]      rdata1,
    output logic [31:0]      rdata2,
    output logic             wb_regWr,
    output logic [4:0]       wb_regAddr,
    output logic [31:0]      wb_data,
    output logic             trace_valid,
    output logic [31:0]      trace_pc,
    output logic [31:0]      trace_inst,
    output logic             trace_we,
    output logic [4:0]       trace_waddr,
    output logic [31:0]      trace_wdata,
    output logic [CNT_W-1:0] retired
);

    logic [31:0]      wb_data_r;
    logic [4:0]       wb_addr_r;
    logic             wb_wr_r;
    logic             wb_valid_r;
    logic [31:0]      wb_inst_r;
    logic [31:0]      wb_pc_r;
    logic [31:0]      rf_r [32];
    logic [CNT_W-1:0] retired_r;
    logic             wb_we_s;
    logic [31:0]      rdata1_s;
    logic [31:0]      rdata2_s;

    // Bubbles and r0 destinations never reach the register file.
    assign wb_we_s = wb_wr_r & wb_valid_r & (wb_addr_r != 5'd0);

    // Stage register: captures the memory-access result every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data_r  <= 32'd0;
            wb_addr_r  <= 5'd0;
            wb_wr_r    <= 1'b0;
            wb_valid_r <= 1'b0;
            wb_inst_r  <= 32'd0;
            wb_pc_r    <= 32'd0;
        end else begin
            wb_data_r  <= regData_i;
            wb_addr_r  <= regAddr_i;
            wb_wr_r    <= regWr_i;
            wb_valid_r <= valid_i;
            wb_inst_r  <= inst_debug_i;
            wb_pc_r    <= pc_debug_i;
        end
    end

    // Register file storage; reset clears every entry and drops any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= 32'd0;
            end
        end else if (wb_we_s) begin
            rf_r[wb_addr_r] <= wb_data_r;
        end
    end

    // Retired-instruction counter, wraps freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_r <= '0;
        end else if (wb_valid_r) begin
            retired_r <= retired_r + CNT_W'(1);
        end
    end

    // Read port 1: r0, then youngest WB value, then storage.
    always_comb begin
        rdata1_s = 32'd0;
        if (raddr1 == 5'd0) begin
            rdata1_s = 32'd0;
        end else if (wb_we_s && (raddr1 == wb_addr_r)) begin
            rdata1_s = wb_data_r;
        end else begin
            rdata1_s = rf_r[raddr1];
        end
    end

    // Read port 2: identical priority to port 1.
    always_comb begin
        rdata2_s = 32'd0;
        if (raddr2 == 5'd0) begin
            rdata2_s = 32'd0;
        end else if (wb_we_s && (raddr2 == wb_addr_r)) begin
            rdata2_s = wb_data_r;
        end else begin
            rdata2_s = rf_r[raddr2];
        end
    end

    assign rdata1      = rdata1_s;
    assign rdata2      = rdata2_s;
    assign wb_regWr    = wb_we_s;
    assign wb_regAddr  = wb_addr_r;
    assign wb_data     = wb_data_r;
    assign trace_valid = wb_valid_r;
    assign trace_pc    = wb_pc_r;
    assign trace_inst  = wb_inst_r;
    assign trace_we    = wb_we_s;
    assign trace_waddr = wb_addr_r;
    assign trace_wdata = wb_data_r;
    assign retired     = retired_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver issues instructions and queues expected commits,
// a negedge monitor checks trace/forwarding/read ports against an architectural model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] regData_i = 32'd0;
    logic [4:0]  regAddr_i = 5'd0;
    logic        regWr_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [31:0] inst_debug_i = 32'd0;
    logic [31:0] pc_debug_i = 32'd0;
    logic [4:0]  raddr1 = 5'd0;
    logic [4:0]  raddr2 = 5'd0;

    logic [31:0] rdata1, rdata2, wb_data, trace_pc, trace_inst, trace_wdata, retired;
    logic        wb_regWr, trace_valid, trace_we;
    logic [4:0]  wb_regAddr, trace_waddr;

    logic [31:0] u4_rdata1, u4_rdata2, u4_wb_data, u4_trace_pc, u4_trace_inst, u4_trace_wdata;
    logic        u4_wb_regWr, u4_trace_valid, u4_trace_we;
    logic [4:0]  u4_wb_regAddr, u4_trace_waddr;
    logic [3:0]  u4_retired;

    wb_regfile #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .regData_i(regData_i), .regAddr_i(regAddr_i), .regWr_i(regWr_i),
        .valid_i(valid_i), .inst_debug_i(inst_debug_i), .pc_debug_i(pc_debug_i),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .wb_regWr(wb_regWr), .wb_regAddr(wb_regAddr), .wb_data(wb_data),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_inst(trace_inst),
        .trace_we(trace_we), .trace_waddr(trace_waddr), .trace_wdata(trace_wdata),
        .retired(retired)
    );

    // Narrow-counter instance shares all inputs; only its retire count is checked.
    wb_regfile #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .regData_i(regData_i), .regAddr_i(regAddr_i), .regWr_i(regWr_i),
        .valid_i(valid_i), .inst_debug_i(inst_debug_i), .pc_debug_i(pc_debug_i),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(u4_rdata1), .rdata2(u4_rdata2),
        .wb_regWr(u4_wb_regWr), .wb_regAddr(u4_wb_regAddr), .wb_data(u4_wb_data),
        .trace_valid(u4_trace_valid), .trace_pc(u4_trace_pc), .trace_inst(u4_trace_inst),
        .trace_we(u4_trace_we), .trace_waddr(u4_trace_waddr), .trace_wdata(u4_trace_wdata),
        .retired(u4_retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rec_t;

    rec_t        exp_q[$];
    logic [31:0] m_rf [32];
    logic        m_valid = 1'b0;
    logic [31:0] exp_retired = 32'd0;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        exp_q.delete();
        m_valid = 1'b0;
        exp_retired = 32'd0;
    endtask

    // Apply one instruction, wait for the capture edge, then update the architectural model.
    task automatic drive(input logic v, input logic wr, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] r1, input logic [4:0] r2);
        rec_t r;
        valid_i = v; regWr_i = wr; regAddr_i = a; regData_i = d;
        inst_debug_i = $urandom; pc_debug_i = $urandom;
        raddr1 = r1; raddr2 = r2;
        if (v) begin
            r.pc = pc_debug_i; r.inst = inst_debug_i;
            r.we = wr && (a != 5'd0); r.waddr = a; r.wdata = d;
            exp_q.push_back(r);
        end
        @(posedge clk);
        exp_retired = exp_retired + 32'(m_valid);
        m_valid = v;
        if (v && wr && (a != 5'd0)) m_rf[a] = d;
        #1;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        drive(1'b0, 1'b0, 5'd0, 32'd0, r1, r2);
    endtask

    // Monitor: pop an expected commit whenever the DUT shows one, and check reads every cycle.
    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            chk("trace_valid", 32'(trace_valid), 32'(m_valid));
            if (trace_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit", 32'(trace_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("trace_pc", trace_pc, e.pc);
                    chk("trace_inst", trace_inst, e.inst);
                    chk("trace_we", 32'(trace_we), 32'(e.we));
                    chk("wb_regWr", 32'(wb_regWr), 32'(e.we));
                    chk("trace_waddr", 32'(trace_waddr), 32'(e.waddr));
                    chk("wb_regAddr", 32'(wb_regAddr), 32'(e.waddr));
                    chk("trace_wdata", trace_wdata, e.wdata);
                    chk("wb_data", wb_data, e.wdata);
                end
            end else begin
                chk("idle_trace_we", 32'(trace_we), 32'd0);
                chk("idle_wb_regWr", 32'(wb_regWr), 32'd0);
            end
            chk("rdata1", rdata1, m_rf[raddr1]);
            chk("rdata2", rdata2, m_rf[raddr2]);
            chk("retired", retired, exp_retired);
            chk("retired4", 32'(u4_retired), 32'(exp_retired[3:0]));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        logic [4:0]  a, r1, r2;
        logic        v, wr;
        model_clear();
        #13 rst = 1'b0;

        // Preload r5, leave r6 pending, then reset between edges.
        drive(1'b1, 1'b1, 5'd5, 32'h0000_1234, 5'd5, 5'd6);
        drive(1'b1, 1'b1, 5'd6, 32'h0000_AAAA, 5'd5, 5'd6);
        chk("preload_r5", rdata1, 32'h0000_1234);
        valid_i = 1'b0; regWr_i = 1'b0;
        #1 rst = 1'b1;
        model_clear();
        #1;
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_rdata2", rdata2, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_trace_valid", 32'(trace_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        idle(5'd5, 5'd6);
        chk("post_rst_r5", rdata1, 32'd0);
        chk("post_rst_r6", rdata2, 32'd0);

        // Seventeen commits wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 5'(10 + (i % 10)), $urandom, 5'(10 + (i % 10)), 5'd0);
        end
        idle(5'd0, 5'd0);
        chk("wrap_retired4", 32'(u4_retired), 32'd1);
        chk("wrap_retired", retired, 32'd17);

        // Write with bypass, then from storage.
        drive(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd0);
        chk("bypass_rdata1", rdata1, 32'hDEAD_BEEF);
        chk("bypass_wb_regWr", 32'(wb_regWr), 32'd1);
        chk("bypass_wb_regAddr", 32'(wb_regAddr), 32'd7);
        idle(5'd7, 5'd0);
        chk("stored_rdata1", rdata1, 32'hDEAD_BEEF);

        // r0 write is traced and counted but never stored.
        base = retired;
        drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        chk("r0_rdata1", rdata1, 32'd0);
        chk("r0_trace_valid", 32'(trace_valid), 32'd1);
        chk("r0_trace_we", 32'(trace_we), 32'd0);
        idle(5'd0, 5'd0);
        chk("r0_retired", retired, base + 32'd1);

        // Bubble with write enable leaves everything untouched.
        base = retired;
        drive(1'b0, 1'b1, 5'd3, 32'h0000_0055, 5'd3, 5'd3);
        chk("bubble_trace_valid", 32'(trace_valid), 32'd0);
        chk("bubble_rdata1", rdata1, 32'd0);
        idle(5'd3, 5'd3);
        chk("bubble_retired", retired, base);
        chk("bubble_r3", rdata2, 32'd0);

        // Back-to-back writes to r9 seen on both ports.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 5'd9, 32'(i), 5'd9, 5'd9);
            chk("same_reg_p1", rdata1, 32'(i));
            chk("same_reg_p2", rdata2, 32'(i));
        end
        idle(5'd9, 5'd9);
        chk("same_reg_final", rdata1, 32'd3);

        // Randomized traffic biased toward a few registers to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 4) != 0);
            a  = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            r1 = ($urandom_range(0, 1) == 0) ? a : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 1) == 0) ? a : 5'($urandom_range(0, 3));
            drive(v, wr, a, $urandom, r1, r2);
        end
        idle(5'd1, 5'd2);
        idle(5'd3, 5'd4);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
